// File: rtl/multi_alarm_reporter_pkg.sv
// Shared constants for the alarm report path: frame layout, ASCII codes, FSM states.
// The alarm-setting parser uses the same ASCII codes, so a report frame loops back cleanly.
package multi_alarm_reporter_pkg;

  localparam int unsigned FRAME_LEN = 12;
  localparam int unsigned N_ALARMS  = 3;

  localparam logic [3:0] IDX_LAST = 4'(FRAME_LEN - 1);

  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rstate_e;

endpackage

// File: rtl/multi_alarm_reporter_bin2ascii2.sv
// Binary 0..63 to two ASCII decimal digits (tens, units); purely combinational.
module bin2ascii2
  import multi_alarm_reporter_pkg::*;
(
  input  logic [5:0] bin_i,
  output logic [7:0] tens_o,
  output logic [7:0] units_o
);

  logic [5:0] tens;
  logic [5:0] units;

  assign tens    = bin_i / 6'd10;
  assign units   = bin_i % 6'd10;
  assign tens_o  = CH_ZERO + {2'b00, tens};
  assign units_o = CH_ZERO + {2'b00, units};

endmodule

// File: rtl/multi_alarm_reporter.sv
// Serializes a snapshotted alarm time as "Hn:HH:MM:SS\n" over a valid/ready byte link.
// Requests are latched in pend flags and served lowest alarm first.
module multi_alarm_reporter
  import multi_alarm_reporter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour1,
  input  logic [4:0] hour2,
  input  logic [4:0] hour3,
  input  logic [5:0] min1,
  input  logic [5:0] min2,
  input  logic [5:0] min3,
  input  logic [5:0] sec1,
  input  logic [5:0] sec2,
  input  logic [5:0] sec3,
  input  logic [2:0] req,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);

  rstate_e    state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] pend_q, pend_d;
  logic [1:0] sel_q, sel_d;
  logic [5:0] hr_q, hr_d;
  logic [5:0] mn_q, mn_d;
  logic [5:0] sc_q, sc_d;
  logic       done_q, done_d;
  logic [2:0] clr;

  logic [7:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;

  bin2ascii2 u_hr (.bin_i(hr_q), .tens_o(hr_t), .units_o(hr_u));
  bin2ascii2 u_mn (.bin_i(mn_q), .tens_o(mn_t), .units_o(mn_u));
  bin2ascii2 u_sc (.bin_i(sc_q), .tens_o(sc_t), .units_o(sc_u));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= R_IDLE;
      idx_q   <= 4'd0;
      pend_q  <= 3'b000;
      sel_q   <= 2'd0;
      hr_q    <= 6'd0;
      mn_q    <= 6'd0;
      sc_q    <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      hr_q    <= hr_d;
      mn_q    <= mn_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    hr_d    = hr_q;
    mn_d    = mn_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    clr     = 3'b000;
    case (state_q)
      R_IDLE: begin
        if (|pend_q) begin
          state_d = R_SEND;
          idx_d   = 4'd0;
          if (pend_q[0]) begin
            clr = 3'b001; sel_d = 2'd1;
            hr_d = {1'b0, hour1}; mn_d = min1; sc_d = sec1;
          end else if (pend_q[1]) begin
            clr = 3'b010; sel_d = 2'd2;
            hr_d = {1'b0, hour2}; mn_d = min2; sc_d = sec2;
          end else begin
            clr = 3'b100; sel_d = 2'd3;
            hr_d = {1'b0, hour3}; mn_d = min3; sc_d = sec3;
          end
        end
      end
      R_SEND: begin
        if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = R_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
    // A request arriving in the clearing cycle keeps its flag set.
    pend_d = (pend_q & ~clr) | req;
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = (state_q == R_SEND);
    busy     = (state_q == R_SEND);
    if (state_q == R_SEND) begin
      case (idx_q)
        4'd0:  tx_data = CH_H;
        4'd1:  tx_data = CH_ZERO + {6'b0, sel_q};
        4'd2:  tx_data = CH_COLON;
        4'd3:  tx_data = hr_t;
        4'd4:  tx_data = hr_u;
        4'd5:  tx_data = CH_COLON;
        4'd6:  tx_data = mn_t;
        4'd7:  tx_data = mn_u;
        4'd8:  tx_data = CH_COLON;
        4'd9:  tx_data = sc_t;
        4'd10: tx_data = sc_u;
        4'd11: tx_data = CH_LF;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_multi_alarm_reporter.sv
// Randomized bench: expected frames come from formatted strings; received frames are re-parsed.
module tb_multi_alarm_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] hour1 = '0, hour2 = '0, hour3 = '0;
  logic [5:0] min1 = '0, min2 = '0, min3 = '0;
  logic [5:0] sec1 = '0, sec2 = '0, sec3 = '0;
  logic [2:0] req = '0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  multi_alarm_reporter dut (
    .clk(clk), .rst(rst),
    .hour1(hour1), .hour2(hour2), .hour3(hour3),
    .min1(min1), .min2(min2), .min3(min3),
    .sec1(sec1), .sec2(sec2), .sec3(sec3),
    .req(req), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_alarm(input int n, input int h, input int m, input int s);
    case (n)
      1: begin hour1 = 5'(h); min1 = 6'(m); sec1 = 6'(s); end
      2: begin hour2 = 5'(h); min2 = 6'(m); sec2 = 6'(s); end
      default: begin hour3 = 5'(h); min3 = 6'(m); sec3 = 6'(s); end
    endcase
  endtask

  function automatic int dig(input logic [7:0] c);
    return int'(c) - 48;
  endfunction

  // Host-side parser: accepts "Hn:HH:MM:SS\n" and returns the fields.
  function automatic bit parse(input logic [7:0] b[12], output int n, output int h,
                               output int m, output int s);
    bit ok;
    ok = (b[0] == 8'h48) && (b[2] == 8'h3A) && (b[5] == 8'h3A) &&
         (b[8] == 8'h3A) && (b[11] == 8'h0A);
    foreach (b[i])
      if (i inside {1, 3, 4, 6, 7, 9, 10})
        ok = ok && (b[i] >= 8'h30) && (b[i] <= 8'h39);
    n = dig(b[1]);
    h = dig(b[3]) * 10 + dig(b[4]);
    m = dig(b[6]) * 10 + dig(b[7]);
    s = dig(b[9]) * 10 + dig(b[10]);
    return ok;
  endfunction

  // Called at a negedge; consumes one frame. exp_wait < 0 skips the latency check.
  task automatic recv_frame(input int n, input int h, input int m, input int s,
                            input bit rnd, input bit mid_change, input logic [2:0] repulse,
                            input int abort_at, input int exp_wait);
    string e;
    logic [7:0] rx[12];
    int w, i, cyc, stall, pn, ph, pm, ps;
    bit pulsed, ok;
    e = $sformatf("H%0d:%02d:%02d:%02d\n", n, h, m, s);
    @(negedge clk);
    req = 3'b000;
    w = 0;
    while (!tx_valid && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!tx_valid) begin
      chk("start_timeout", 32'(tx_valid), 32'd1);
      return;
    end
    if (exp_wait >= 0) chk("latency", 32'(w), 32'(exp_wait));
    i = 0; cyc = 0; stall = 0; pulsed = 1'b0;
    while (i < 12) begin
      cyc++;
      chk("valid_hold", 32'(tx_valid), 32'd1);
      chk($sformatf("byte%0d", i), 32'(tx_data), 32'(e[i]));
      chk("busy", 32'(busy), 32'd1);
      if (mid_change && i == 4) set_alarm(n, 1, 1, 1);
      if (repulse != 3'b000 && i == 3 && !pulsed) begin
        req = repulse; pulsed = 1'b1;
      end else begin
        req = 3'b000;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_ready) begin
        rx[i] = tx_data;
        i++;
      end else begin
        stall++;
      end
      if (stall > 400) begin
        chk("stall_timeout", 32'd1, 32'd0);
        tx_ready = 1'b1;
        return;
      end
      if (abort_at >= 0 && i == abort_at) return;
      @(negedge clk);
    end
    req = 3'b000;
    tx_ready = 1'b1;
    if (!rnd) chk("consecutive", 32'(cyc), 32'd12);
    chk("done", 32'(done), 32'd1);
    chk("idle_after", 32'(tx_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    ok = parse(rx, pn, ph, pm, ps);
    chk("parse_set", 32'(ok), 32'd1);
    chk("parse_n", 32'(pn), 32'(n));
    chk("parse_h", 32'(ph), 32'(h));
    chk("parse_m", 32'(pm), 32'(m));
    chk("parse_s", 32'(ps), 32'(s));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hv[3], mv[3], sv[3];
    int first;
    logic [2:0] pat;
    bit seen;

    #3;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single frame, full-speed sink
    set_alarm(2, 7, 5, 9);
    req = 3'b010;
    recv_frame(2, 7, 5, 9, 1'b0, 1'b0, 3'b000, -1, 1);
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("busy_fell", 32'(busy), 32'd0);

    // All three requested together: priority order, one idle cycle between frames
    set_alarm(1, 23, 59, 59); set_alarm(2, 0, 0, 0); set_alarm(3, 12, 30, 45);
    req = 3'b111;
    recv_frame(1, 23, 59, 59, 1'b0, 1'b0, 3'b000, -1, 1);
    recv_frame(2, 0, 0, 0, 1'b0, 1'b0, 3'b000, -1, 0);
    recv_frame(3, 12, 30, 45, 1'b0, 1'b0, 3'b000, -1, 0);
    repeat (3) @(negedge clk);

    // Random back-pressure with the source changing mid-frame
    set_alarm(1, 10, 20, 30);
    req = 3'b001;
    recv_frame(1, 10, 20, 30, 1'b1, 1'b1, 3'b000, -1, 1);
    repeat (2) @(negedge clk);

    // Top-of-range field values
    set_alarm(3, 31, 63, 63);
    req = 3'b100;
    recv_frame(3, 31, 63, 63, 1'b0, 1'b0, 3'b000, -1, 1);
    repeat (2) @(negedge clk);

    // Re-request of the alarm in flight is served again afterwards
    set_alarm(2, 4, 44, 14);
    req = 3'b010;
    recv_frame(2, 4, 44, 14, 1'b1, 1'b0, 3'b010, -1, 1);
    recv_frame(2, 4, 44, 14, 1'b0, 1'b0, 3'b000, -1, 0);
    repeat (2) @(negedge clk);

    // Reset after byte 5: abort and lose the still-pending alarm 2
    set_alarm(1, 11, 22, 33); set_alarm(2, 5, 6, 7);
    req = 3'b011;
    recv_frame(1, 11, 22, 33, 1'b0, 1'b0, 3'b000, 6, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(tx_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    chk("no_trailing", 32'(seen), 32'd0);

    // Randomized values and request patterns
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < 3; a++) begin
        hv[a] = $urandom_range(0, 31);
        mv[a] = $urandom_range(0, 63);
        sv[a] = $urandom_range(0, 63);
        set_alarm(a + 1, hv[a], mv[a], sv[a]);
      end
      pat = 3'($urandom_range(1, 7));
      req = pat;
      first = 1;
      for (int a = 0; a < 3; a++) begin
        if (pat[a]) begin
          recv_frame(a + 1, hv[a], mv[a], sv[a], 1'($urandom_range(0, 1)), 1'b0, 3'b000,
                     -1, first ? 1 : 0);
          first = 0;
        end
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_alarm_reporter.md
# multi_alarm_reporter

- Serializes stored alarm times back onto the host byte link as ASCII frames `Hn:HH:MM:SS\n`, in exactly the format the alarm-setting parser accepts, so a host can read back alarms or loop them through the parser.
- Sits between the alarm registers and the UART transmitter.
- Takes per-alarm report requests, snapshots the selected binary time and converts it to decimal ASCII.
- Streams 12 bytes through a valid/ready handshake.

## Interface
- (no parameters; frame length 12 and alarm count 3 are fixed constants)
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `hour1`, `hour2`, `hour3` in 5: alarm hours, binary 0..31.
- `min1`, `min2`, `min3` in 6: alarm minutes, binary 0..63.
- `sec1`, `sec2`, `sec3` in 6: alarm seconds, binary 0..63.
- `req` in 3: report request pulses. Bit 0 requests alarm 1, bit 2 requests alarm 3.
- `tx_ready` in 1: the UART transmitter can accept a byte.
- `tx_data` out 8: ASCII byte being offered.
- `tx_valid` out 1: `tx_data` is valid.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse after the last byte (`\n`) is accepted.

## Operation
- Reset values, applied immediately while `rst` = 0:
  - `tx_valid` = 0, `tx_data` = 8'h00, `busy` = 0, `done` = 0.
  - Pending flags cleared, state = IDLE, byte index = 0.
- Pending flags:
  - On every clock, `pend[i]` is set by `req[i]`.
  - `pend[i]` is cleared only when a frame for alarm i starts.
  - A `req[i]` in the same cycle as that clear wins: the flag stays set.
- IDLE, with any pending flag set:
  - Select the lowest-numbered pending alarm (priority 1 > 2 > 3).
  - Clear its flag and snapshot its hour/min/sec into internal registers.
  - Set byte index = 0 and go to SEND.
- SEND:
  - `tx_data` = frame byte at the current index, `tx_valid` = 1, `busy` = 1.
  - On `tx_valid` && `tx_ready`: the index increments.
  - At index 11 the FSM returns to IDLE instead, and `done` pulses.
- Frame bytes by index:
  - 0: `"H"`
  - 1: `"0"` + n
  - 2, 5, 8: `":"`
  - 3, 4: hour tens, hour units
  - 6, 7: minute tens, minute units
  - 9, 10: second tens, second units
  - 11: `8'h0A`
- Decimal conversion:
  - Each field is converted as tens = v / 10 and units = v mod 10, each + 8'h30.
  - Valid for the full input range 0..63. Example: 63 → `"6"`, `"3"`; 7 → `"0"`, `"7"`.
  - There is no range clamping.
- Snapshot: alarm inputs changing during SEND do not affect the frame in flight.
- A request for the alarm currently being sent re-pends it, and it is sent again after the current frame.

## Timing
- Request latency:
  - `req` sampled high at edge k with the FSM in IDLE: `tx_valid` rises after edge k+1, and byte 0 is `"H"`.
  - The IDLE state and pend register add one cycle in total.
- Handshake:
  - `tx_data` stays stable while `tx_valid` = 1 and `tx_ready` = 0.
  - `tx_valid` never drops before acceptance.
  - `tx_valid` does not depend combinationally on `tx_ready`.
- Throughput: with `tx_ready` held high, the 12 bytes go out on 12 consecutive cycles.
- `done`: asserted in the cycle after byte 11 is accepted, coincident with IDLE.
- Back-to-back frames: a pending request at `done` produces the next frame's `tx_valid` one cycle later, so there is one idle cycle between frames.
- Reset mid-frame: the frame is aborted with no trailing bytes, and pending requests are lost.

## Structure
- Shared package/header constants: `FRAME_LEN` = 12, ASCII codes `CH_H`, `CH_COLON`, `CH_LF`, `CH_ZERO`, and FSM encodings `R_IDLE`, `R_SEND`.
  - The parser uses the same ASCII constants.
- One sub-module: `bin2ascii2`, combinational.
  - Input: 6-bit binary.
  - Output: two 8-bit ASCII digits.
  - Instantiated three times (hour zero-extended, minute, second).
- Top level holds the pend flags, priority select, snapshot registers, index counter and output mux.

## Test plan
- Alarm 2 = 07:05:09, `req` = 3'b010, `tx_ready` = 1:
  - Bytes `"H2:07:05:09\n"` on 12 consecutive cycles.
  - `done` pulses once, and `busy` falls.
- `req` = 3'b111 in a single cycle, alarms 1 = 23:59:59, 2 = 00:00:00, 3 = 12:30:45:
  - Frames for alarms 1, 2, 3 in that order, one idle cycle between frames.
- `tx_ready` toggled pseudo-randomly, with alarm 1 changed to 01:01:01 mid-frame:
  - `tx_data` stays stable while stalled.
  - The frame still shows the snapshotted value 10:20:30.
- Field value 63 on the seconds input: the seconds digits are `"6"`, `"3"`.
- `rst` asserted after byte 5: `tx_valid` drops asynchronously, and no further bytes are sent until a new `req`.
- Loopback: reporter output fed into the alarm parser.
  - The parser's `set` pulse for the same alarm fires.
  - The parser's hour/min/sec match the source values for all three alarms.
